// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes i0 - i1 - bin, DIGIT bits per clock,
// least-significant digit first, with borrow, unsigned borrow-out and signed overflow.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             ovf_dig;

    // Top bit of the (DIGIT+1)-bit difference is the digit's borrow-out.
    always_comb begin
        a_dig   = a_sh[DIGIT-1:0];
        b_dig   = b_sh[DIGIT-1:0];
        dsum    = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, br};
        ovf_dig = (a_dig[DIGIT-1] ^ b_dig[DIGIT-1])
                & (a_dig[DIGIT-1] ^ dsum[DIGIT-1]);
        res_nxt = d >> DIGIT;
        res_nxt[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= i0;
                        b_sh  <= i1;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    d    <= res_nxt;
                    br   <= dsum[DIGIT];
                    bout <= dsum[DIGIT];
                    ovf  <= ovf_dig;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic reference model with per-cycle
// checking, directed corner cases and an exhaustive 4-bit sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic       start84 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic [7:0] d8, d84;
    logic       bo8, ov8, busy8, done8;
    logic       bo84, ov84, busy84, done84;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       c4 = 1'b0;
    logic [3:0] d4 [3];
    logic [2:0] bo4, ov4, busy4, done4;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .i0(a8), .i1(b8),
        .bin(c8), .d(d8), .bout(bo8), .ovf(ov8), .busy(busy8), .done(done8));

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start(start84), .i0(a8), .i1(b8),
        .bin(c8), .d(d84), .bout(bo84), .ovf(ov84), .busy(busy84), .done(done84));

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u4_1 (
        .clk(clk), .rst_n(rst_n), .start(start4), .i0(a4), .i1(b4),
        .bin(c4), .d(d4[0]), .bout(bo4[0]), .ovf(ov4[0]), .busy(busy4[0]), .done(done4[0]));

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) u4_2 (
        .clk(clk), .rst_n(rst_n), .start(start4), .i0(a4), .i1(b4),
        .bin(c4), .d(d4[1]), .bout(bo4[1]), .ovf(ov4[1]), .busy(busy4[1]), .done(done4[1]));

    serial_subtractor #(.WIDTH(4), .DIGIT(4)) u4_4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .i0(a4), .i1(b4),
        .bin(c4), .d(d4[2]), .bout(bo4[2]), .ovf(ov4[2]), .busy(busy4[2]), .done(done4[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned difference and signed range test.
    function automatic void refm(input int w, input int a, input int b, input int c,
                                 output int rd, output int rbo, output int rov);
        int full, sa, sb, sd;
        full = a - b - c;
        rd   = full & ((1 << w) - 1);
        rbo  = (full < 0) ? 1 : 0;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd   = sa - sb - c;
        rov  = (sd < -(1 << (w - 1)) || sd >= (1 << (w - 1))) ? 1 : 0;
    endfunction

    // Timing model for u8: an accepted op completes 8 edges later.
    int m_busy = 0, m_done = 0, m_d = 0, m_bo = 0, m_ov = 0, m_left = 0;
    int p_d = 0, p_bo = 0, p_ov = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_d = 0; m_bo = 0; m_ov = 0; m_left = 0;
        end else if (m_busy != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                m_d = p_d; m_bo = p_bo; m_ov = p_ov;
            end
        end else begin
            m_done = 0;
            if (start8) begin
                m_busy = 1;
                m_left = 8;
                refm(8, int'(a8), int'(b8), int'(c8), p_d, p_bo, p_ov);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", 32'(busy8), 32'(m_busy));
            chk("m_done", 32'(done8), 32'(m_done));
            if (m_busy == 0) begin
                chk("m_d", 32'(d8), 32'(m_d));
                chk("m_bout", 32'(bo8), 32'(m_bo));
                chk("m_ovf", 32'(ov8), 32'(m_ov));
            end
        end
    end

    task automatic op(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic c, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c;
        if (sel == 0) start8 = 1'b1;
        else start84 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        start84 = 1'b0;
        lat = 0;
        while (!(sel == 0 ? done8 : done84) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, nd, dd, ed, eb, eo, cyc;
        logic [7:0] x;
        logic [2:0] seen;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_d", 32'(d8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h00, 8'h01, 1'b0, lat);
        chk("r33_lat", lat, 8);
        chk("r33_d", 32'(d8), 32'hFF);
        chk("r33_bout", 32'(bo8), 1);
        chk("r33_ovf", 32'(ov8), 0);

        op(0, 8'h80, 8'h01, 1'b0, lat);
        chk("r34_d", 32'(d8), 32'h7F);
        chk("r34_bout", 32'(bo8), 0);
        chk("r34_ovf", 32'(ov8), 1);

        x = 8'($urandom);
        op(0, x, x, 1'b0, lat);
        chk("r28_d", 32'(d8), 0);
        chk("r28_bout", 32'(bo8), 0);
        chk("r28_ovf", 32'(ov8), 0);
        op(0, x, x, 1'b1, lat);
        chk("r29_d", 32'(d8), 32'hFF);
        chk("r29_bout", 32'(bo8), 1);
        chk("r29_ovf", 32'(ov8), 0);

        op(1, 8'h05, 8'h03, 1'b1, lat);
        chk("r35_lat", lat, 2);
        chk("r35_d", 32'(d84), 32'h01);
        chk("r35_bout", 32'(bo84), 0);
        chk("r35_ovf", 32'(ov84), 0);
        chk("r35_busy", 32'(busy84), 0);

        for (int i = 0; i < 30; i++) begin
            op(1, 8'($urandom), 8'($urandom), 1'($urandom), lat);
            refm(8, int'(a8), int'(b8), int'(c8), ed, eb, eo);
            chk("d4r_lat", lat, 2);
            chk("d4r_d", 32'(d84), 32'(ed));
            chk("d4r_bout", 32'(bo84), 32'(eb));
            chk("d4r_ovf", 32'(ov84), 32'(eo));
        end

        // Second start during RUN must be ignored.
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h15; c8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nd = 0; dd = -1;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                a8 = 8'hC4; b8 = 8'h99; c8 = 1'b1; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            if (done8) begin
                nd++;
                dd = int'(d8);
            end
        end
        start8 = 1'b0;
        chk("r36_dones", nd, 1);
        chk("r36_d", dd, 32'h22);

        // Reset in the 4th RUN cycle aborts; start is ignored while in reset.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("r37_busy_pre", 32'(busy8), 1);
        rst_n = 1'b0;
        start8 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("r37_busy", 32'(busy8), 0);
            chk("r37_done", 32'(done8), 0);
            chk("r37_d", 32'(d8), 0);
            chk("r37_bout", 32'(bo8), 0);
            chk("r37_ovf", 32'(ov8), 0);
        end
        start8 = 1'b0;
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("r37_nodone", nd, 0);
        op(0, 8'h5A, 8'h3C, 1'b0, lat);
        chk("r37_lat", lat, 8);
        chk("r37_d2", 32'(d8), 32'h1E);

        // start held high: one op accepted per DONE cycle.
        @(negedge clk);
        start8 = 1'b1;
        nd = 0;
        for (int k = 0; k < 36; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            @(negedge clk);
            if (done8) nd++;
        end
        start8 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("r27_dones", nd, 4);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            start8 = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        start8 = 1'b0;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    a4 = 4'(a); b4 = 4'(b); c4 = 1'(c); start4 = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
                    refm(4, a, b, c, ed, eb, eo);
                    seen = '0;
                    cyc = 0;
                    while (seen != 3'b111 && cyc < 20) begin
                        for (int k = 0; k < 3; k++) begin
                            if (!seen[k] && done4[k]) begin
                                seen[k] = 1'b1;
                                chk($sformatf("w4_d%0d_d", k), 32'(d4[k]), 32'(ed));
                                chk($sformatf("w4_d%0d_bout", k), 32'(bo4[k]), 32'(eb));
                                chk($sformatf("w4_d%0d_ovf", k), 32'(ov4[k]), 32'(eo));
                                chk($sformatf("w4_d%0d_busy", k), 32'(busy4[k]), 0);
                            end
                        end
                        if (seen != 3'b111) begin
                            @(negedge clk);
                            cyc++;
                        end
                    end
                    if (seen != 3'b111) chk("w4_timeout", 32'(seen), 32'h7);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving the bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-006 The block SHALL have port i0, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port i1, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 The block SHALL have port d, output, WIDTH bits: difference.
REQ-010 The block SHALL have port bout, output, 1 bit: borrow-out of the MSB.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at a clock edge SHALL be accepted: i0, i1 and bin are latched, the digit counter is cleared, and the state moves to RUN.
REQ-016 start SHALL be ignored in RUN; the latched operands SHALL be unaffected by later changes on i0, i1 and bin.
REQ-017 Each RUN cycle SHALL compute the next DIGIT least-significant bits, lowest digit first: digit result = a_digit - b_digit - borrow, and the internal borrow SHALL update to that digit's borrow-out.
REQ-018 After exactly N RUN cycles, the state SHALL move to DONE; RUN to DONE SHALL have no other exit except reset.
REQ-019 DONE SHALL last one cycle, with done=1, then move to IDLE unless a new start is accepted (REQ-015).
REQ-020 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E0+N.
REQ-021 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-022 d SHALL equal (i0 - i1 - bin) mod 2^WIDTH.
REQ-023 bout SHALL equal 1 iff i0 < i1 + bin, treated as unsigned.
REQ-024 ovf SHALL equal the borrow into the MSB XOR the borrow out of the MSB.
REQ-025 d, bout and ovf SHALL be valid from the DONE cycle and held stable until the next accepted start.
REQ-026 d, bout and ovf MAY change during RUN and SHALL NOT be sampled by users then.
REQ-027 A start held high continuously SHALL produce back-to-back operations: one accepted in each DONE cycle, and none lost or duplicated.
REQ-028 Operands i0 = i1 with bin=0 SHALL give d=0, bout=0, ovf=0.
REQ-029 Operands i0 = i1 with bin=1 SHALL give d=all ones, bout=1, ovf=0.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force state IDLE, busy=0, done=0, d=0, bout=0, ovf=0, and clear the counter and internal borrow, regardless of current state.
REQ-031 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after rst_n returns to 1 SHALL be accepted normally.
REQ-032 start SHALL be ignored while rst_n=0.

Verification (WIDTH=8 unless stated)
REQ-033 DIGIT=1, i0=0x00, i1=0x01, bin=0 -> done 9 cycles after start edge, d=0xFF, bout=1, ovf=0.
REQ-034 DIGIT=1, i0=0x80, i1=0x01, bin=0 -> d=0x7F, bout=0, ovf=1.
REQ-035 DIGIT=4, i0=0x05, i1=0x03, bin=1 -> done 3 cycles after start edge, d=0x01, bout=0, ovf=0.
REQ-036 Start accepted, then start pulsed again during RUN with different operands -> only the first result appears, with exactly one done pulse.
REQ-037 rst_n=0 in the 4th RUN cycle -> busy=0, no done pulse, outputs 0; a new start then completes correctly.
REQ-038 Exhaustive sweep with WIDTH=4, DIGIT in {1,2,4}, over all i0, i1 and bin -> d, bout and ovf match the REQ-022..024 reference model.
